nios2_in_event_ctrl: RTL and testbench

Event-capturing controller for an 8-bit parallel input port on the Nios II Avalon-MM bus. It synchronises and debounces `in_port`, timestamps every debounced change, and queues `{timestamp, value}` events in a small FIFO. Software reads the FIFO through a 4-word register window and receives an interrupt instead of polling the raw port. The block sits between the board input pins and the system interconnect.

---
 rtl/nios2_in_event_pkg.sv | 39 +++
 rtl/nios2_in_event_fifo.sv | 77 +++++++
 rtl/nios2_in_event_ctrl.sv | 156 +++++++++++++++
 tb/tb_nios2_in_event_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_in_event_pkg.sv
// Shared constants for the Nios II input event controller.
// Register map, STATUS/CONTROL bit positions and EVENT word layout.
package nios2_in_event_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_EVENT  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_CNT_LSB   = 0;
    localparam int STAT_CNT_W     = 8;
    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_EMPTY_BIT = 9;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    localparam int EV_VALID_BIT = 0;
    localparam int EV_VAL_LSB   = 8;
    localparam int EV_VAL_W     = 8;
    localparam int EV_TS_LSB    = 16;
    localparam int EV_TS_W      = 16;

    typedef logic [EV_TS_W-1:0] ts_t;

    function automatic logic [31:0] pack_event(
        input ts_t                 ts,
        input logic [EV_VAL_W-1:0] val
    );
        logic [31:0] w;
        w = '0;
        w[EV_TS_LSB +: EV_TS_W]   = ts;
        w[EV_VAL_LSB +: EV_VAL_W] = val;
        w[EV_VALID_BIT]           = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/nios2_in_event_fifo.sv
// Event FIFO: push/pop/flush with registered occupancy count.
// Flush overrides everything; a push into a full FIFO is kept only if a pop frees a slot.
module nios2_in_event_fifo
    import nios2_in_event_pkg::*;
#(
    parameter int DW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DW-1:0]            data_i,
    output logic [DW-1:0]            data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;
    assign drop_o  = push_i & full_o & ~pop_ok & ~flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)
                count_d = count_q + 1'b1;
            else if (!push_ok && pop_ok)
                count_d = count_q - 1'b1;
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/nios2_in_event_ctrl.sv
// Input event controller: sync, debounce, timestamp and queue input changes.
// Software drains events through a 4-word Avalon-MM window with an irq.
module nios2_in_event_ctrl
    import nios2_in_event_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int DW = EV_TS_W + WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0] sync1_q, sync_q;
    logic [WIDTH-1:0] debounced_q;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    ts_t              ts_q;
    logic             enable_q, irq_en_q;
    logic             overflow_q, overflow_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             change;
    logic             push;
    logic             pop;
    logic             flush;
    logic             wr_ctrl, wr_stat;
    logic [DW-1:0]    fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty, fifo_drop;
    ts_t              head_ts;
    logic [WIDTH-1:0] head_val;
    logic             unused_wdata;

    assign change  = (stable_cnt_q == CNT_MAX) && (sync_q != debounced_q);
    assign push    = change & enable_q;
    assign wr_ctrl = write && (address == ADDR_CTRL);
    assign wr_stat = write && (address == ADDR_STATUS);
    assign flush   = wr_ctrl & writedata[CTRL_FLUSH_BIT];
    assign pop     = read && (address == ADDR_EVENT);

    assign head_ts  = fifo_dout[DW-1 -: EV_TS_W];
    assign head_val = fifo_dout[WIDTH-1:0];

    assign unused_wdata = ^{writedata[31:9], writedata[7:3], fifo_full};

    nios2_in_event_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({ts_q, sync_q}),
        .data_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    // Stability counter: restart whenever the next synced sample differs.
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (sync1_q != sync_q)
            stable_cnt_d = '0;
        else if (stable_cnt_q != CNT_MAX)
            stable_cnt_d = stable_cnt_q + 1'b1;
    end

    // Synchroniser, debouncer and timestamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync_q       <= '0;
            debounced_q  <= '0;
            stable_cnt_q <= '0;
            ts_q         <= '0;
        end else begin
            sync1_q      <= in_port;
            sync_q       <= sync1_q;
            stable_cnt_q <= stable_cnt_d;
            if (change) debounced_q <= sync_q;
            if (enable_q) ts_q <= ts_q + 1'b1;
        end
    end

    // Sticky overflow: a dropped event wins over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop)
            overflow_d = 1'b1;
        else if (wr_stat && writedata[STAT_OVF_BIT])
            overflow_d = 1'b0;
    end

    // Read mux; EVENT sees the head before a pop advances it.
    always_comb begin
        readdata_d = '0;
        unique case (address)
            ADDR_DATA:   readdata_d = 32'(debounced_q);
            ADDR_EVENT:
                if (!fifo_empty)
                    readdata_d = pack_event(head_ts, EV_VAL_W'(head_val));
            ADDR_STATUS: begin
                readdata_d[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
                readdata_d[STAT_OVF_BIT]               = overflow_q;
                readdata_d[STAT_EMPTY_BIT]             = fifo_empty;
            end
            ADDR_CTRL: begin
                readdata_d[CTRL_EN_BIT]     = enable_q;
                readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            default:     readdata_d = '0;
        endcase
    end

    assign irq_d = irq_en_q & ((fifo_count != '0) | overflow_q);

    // Control, status and bus output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= writedata[CTRL_EN_BIT];
                irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
            end
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_in_event_ctrl.sv
// Self-checking bench for nios2_in_event_ctrl.
// Register reads go through an expected-value queue; events through a model FIFO.
module tb_nios2_in_event_ctrl;
    import nios2_in_event_pkg::*;

    localparam int DC    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'd0;
    logic        irq;

    nios2_in_event_ctrl #(
        .WIDTH           (8),
        .FIFO_DEPTH      (DEPTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    int e_edge = 0;

    logic [31:0] ev_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t rst_tbl[4];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(logic [1:0] a, logic [31:0] exp, string nm);
        logic [31:0] e;
        string s;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        address = a;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        e = exp_q.pop_front();
        s = name_q.pop_front();
        check(s, readdata, e);
    endtask

    task automatic rd_ev(string nm);
        logic [31:0] e;
        e = 32'd0;
        if (ev_q.size() > 0) e = ev_q.pop_front();
        rd(ADDR_EVENT, e, nm);
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        writedata = 32'd0;
    endtask

    // Change the pins now; the push lands DC+2 edges later.
    task automatic chg(logic [7:0] v, bit accept);
        int p;
        in_port = v;
        p = cyc + 2 + DC;
        if (accept)
            ev_q.push_back({16'(p - e_edge - 1), v, 7'd0, 1'b1});
    endtask

    task automatic chk_irq(string nm, logic exp);
        check(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_tbl[0] = '{ADDR_DATA,   32'h0000_0000, "rst_data"};
        rst_tbl[1] = '{ADDR_EVENT,  32'h0000_0000, "rst_event"};
        rst_tbl[2] = '{ADDR_STATUS, 32'h0000_0200, "rst_status"};
        rst_tbl[3] = '{ADDR_CTRL,   32'h0000_0000, "rst_ctrl"};

        idle(3);
        check("rst_readdata", readdata, 32'd0);
        chk_irq("rst_irq", 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            rd(rst_tbl[i].addr, rst_tbl[i].exp, rst_tbl[i].name);

        wr(ADDR_CTRL, 32'h1);
        e_edge = cyc;

        // Short glitch is filtered.
        in_port = 8'hFF;
        idle(2);
        in_port = 8'h00;
        idle(8);
        rd(ADDR_DATA, 32'h0, "glitch_data");
        rd(ADDR_STATUS, 32'h200, "glitch_status");

        // Single step and latency.
        chg(8'h5A, 1'b1);
        idle(5);
        rd(ADDR_DATA, 32'h0, "step_data_early");
        rd(ADDR_STATUS, 32'h001, "step_status");
        rd(ADDR_DATA, 32'h5A, "step_data");
        rd_ev("step_event");
        rd_ev("step_event_empty");

        // Overflow with nine changes.
        for (int i = 0; i < 9; i++) begin
            chg(8'(i + 1), ev_q.size() < DEPTH);
            idle(6);
        end
        rd(ADDR_STATUS, 32'h108, "ovf_status");
        for (int i = 0; i < 8; i++) rd_ev("ovf_event");
        rd(ADDR_STATUS, 32'h300, "ovf_drained");

        // Flush on the same edge as a push, overflow left set.
        for (int i = 0; i < 3; i++) begin
            chg(8'(8'h21 + i), 1'b1);
            idle(6);
        end
        chg(8'h24, 1'b0);
        idle(5);
        wr(ADDR_CTRL, 32'h5);
        ev_q.delete();
        rd(ADDR_STATUS, 32'h300, "flush_status");
        rd_ev("flush_event");
        rd(ADDR_CTRL, 32'h1, "flush_ctrl");
        rd(ADDR_DATA, 32'h24, "flush_data");
        wr(ADDR_STATUS, 32'h100);
        rd(ADDR_STATUS, 32'h200, "ovf_clear");

        // Full FIFO, push and pop on the same edge.
        for (int i = 0; i < 8; i++) begin
            chg(8'(8'h31 + i), 1'b1);
            idle(6);
        end
        rd(ADDR_STATUS, 32'h008, "full_status");
        chg(8'h39, 1'b1);
        idle(5);
        rd_ev("fullpop_event");
        rd(ADDR_STATUS, 32'h008, "fullpop_status");
        for (int i = 0; i < 8; i++) rd_ev("fullpop_drain");
        rd(ADDR_STATUS, 32'h200, "fullpop_empty");

        // irq rises and falls one cycle after count.
        wr(ADDR_CTRL, 32'h3);
        chg(8'h40, 1'b1);
        idle(6);
        chk_irq("irq_push_edge", 1'b0);
        idle(1);
        chk_irq("irq_rise", 1'b1);
        rd_ev("irq_event");
        chk_irq("irq_pop_edge", 1'b1);
        idle(1);
        chk_irq("irq_fall", 1'b0);

        wr(ADDR_CTRL, 32'h1);
        chg(8'h41, 1'b1);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            chk_irq("irq_masked", 1'b0);
        end
        rd(ADDR_STATUS, 32'h001, "masked_status");
        rd_ev("masked_event");

        // Disabled: DATA tracks, nothing queued.
        wr(ADDR_CTRL, 32'h0);
        chg(8'h42, 1'b0);
        idle(6);
        rd(ADDR_DATA, 32'h42, "dis_data");
        rd(ADDR_STATUS, 32'h200, "dis_status");

        // Reset with events queued.
        wr(ADDR_CTRL, 32'h1);
        e_edge = cyc;
        chg(8'h43, 1'b1);
        idle(6);
        chg(8'h44, 1'b1);
        idle(6);
        rd(ADDR_STATUS, 32'h002, "pre_reset_status");
        reset_n = 1'b0;
        ev_q.delete();
        idle(2);
        check("mid_rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++)
            rd(rst_tbl[i].addr, rst_tbl[i].exp, rst_tbl[i].name);
        chk_irq("mid_rst_irq", 1'b0);

        // Timestamp wrap across 0xFFFF.
        idle(10);
        wr(ADDR_CTRL, 32'h1);
        e_edge = cyc;
        while (cyc < e_edge + 65529) @(negedge clk);
        chg(8'h50, 1'b1);
        idle(5);
        chg(8'h51, 1'b1);
        idle(6);
        rd(ADDR_STATUS, 32'h002, "wrap_status");
        rd_ev("wrap_event_1");
        rd_ev("wrap_event_2");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
